// File: rtl/reversi_flip_scanner_if.sv
// Purpose: bundles the scanner's controller-side handshake and board-access signals.
// Ports (no interface ports; clk/resetn are plain ports on the scanner):
//   start/pos/set_black[/dry_run]  move request from the controller
//   rd_addr/rd_data                board read path (combinational same-cycle read)
//   reverse_valid/reverse_addr     per-cell flip pulse toward the node array
//   busy/done/flip_count           scan status
// Optional feature macro: REVERSI_DRYRUN_EN adds dry_run.
interface reversi_flip_scanner_if;
  logic       start;
  logic [5:0] pos;
  logic       set_black;
`ifdef REVERSI_DRYRUN_EN
  logic       dry_run;
`endif
  logic [5:0] rd_addr;
  logic [2:0] rd_data;
  logic       reverse_valid;
  logic [5:0] reverse_addr;
  logic       busy;
  logic       done;
  logic [5:0] flip_count;

  // Controller / board side
  modport master (
`ifdef REVERSI_DRYRUN_EN
    output dry_run,
`endif
    output start, pos, set_black, rd_data,
    input  rd_addr, reverse_valid, reverse_addr, busy, done, flip_count
  );

  // Scanner side
  modport slave (
`ifdef REVERSI_DRYRUN_EN
    input  dry_run,
`endif
    input  start, pos, set_black, rd_data,
    output rd_addr, reverse_valid, reverse_addr, busy, done, flip_count
  );
endinterface

// File: rtl/reversi_flip_scanner.sv
// Purpose: after a move at pos, walks the 8 rays from pos one cell per cycle and emits one
//   reverse pulse per captured opponent cell (nearest to pos first), then pulses done.
// Ports:
//   clk     clock, posedge
//   resetn  asynchronous reset, active-high (despite the name)
//   bus     reversi_flip_scanner_if.slave: start/pos/set_black in, rd_addr/rd_data board
//           read, reverse_valid/reverse_addr flip pulse, busy/done/flip_count status
// Optional feature macro: REVERSI_DRYRUN_EN -- adds dry_run; when latched high the scan
//   counts flips but suppresses reverse_valid (legal-move check).
module reversi_flip_scanner (
  input  logic                   clk,
  input  logic                   resetn,
  reversi_flip_scanner_if.slave  bus
);

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned CRD_W  = 4;
  localparam logic [2:0]  ST_BLACK = 3'd2;
  localparam logic [2:0]  ST_WHITE = 3'd3;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FLIP, S_NEXT, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        pos_q, pos_d;
  logic                     black_q, black_d;
  logic [2:0]               dir_q, dir_d;
  logic [2:0]               run_q, run_d;
  logic signed [CRD_W-1:0]  row_q, row_d, col_q, col_d;
  logic                     rv_q, rv_d;
  logic [ADDR_W-1:0]        ra_q, ra_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d;
  logic                     dry_q, dry_d;

  logic       off_board;
  logic       is_own, is_opp;
  logic [2:0] own_code, opp_code;

  // Row step per direction N,NE,E,SE,S,SW,W,NW
  function automatic logic signed [CRD_W-1:0] step_r(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: step_r = 4'shF;
      3'd3, 3'd4, 3'd5: step_r = 4'sh1;
      default:          step_r = 4'sh0;
    endcase
  endfunction

  // Column step per direction N,NE,E,SE,S,SW,W,NW
  function automatic logic signed [CRD_W-1:0] step_c(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: step_c = 4'sh1;
      3'd5, 3'd6, 3'd7: step_c = 4'shF;
      default:          step_c = 4'sh0;
    endcase
  endfunction

  assign bus.rd_addr       = {row_q[2:0], col_q[2:0]};
  assign bus.reverse_valid = rv_q;
  assign bus.reverse_addr  = ra_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.flip_count    = cnt_q;

  // Cursor coordinates are 4-bit signed: stepping past 7 gives -8, so bit 3 flags off-board.
  assign off_board = row_q[3] | col_q[3];
  assign own_code  = black_q ? ST_BLACK : ST_WHITE;
  assign opp_code  = black_q ? ST_WHITE : ST_BLACK;
  assign is_own    = (bus.rd_data == own_code);
  assign is_opp    = (bus.rd_data == opp_code);

  // Next-state and output computation; outputs follow the next state so they align with it.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    black_d = black_q;
    dir_d   = dir_q;
    run_d   = run_q;
    row_d   = row_q;
    col_d   = col_q;
    ra_d    = ra_q;
    cnt_d   = cnt_q;
    dry_d   = dry_q;
    rv_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pos_d   = bus.pos;
          black_d = bus.set_black;
`ifdef REVERSI_DRYRUN_EN
          dry_d   = bus.dry_run;
`else
          dry_d   = 1'b0;
`endif
          cnt_d   = '0;
          dir_d   = '0;
          run_d   = '0;
          row_d   = $signed({1'b0, bus.pos[5:3]}) + step_r(3'd0);
          col_d   = $signed({1'b0, bus.pos[2:0]}) + step_c(3'd0);
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (off_board || !(is_own || is_opp)) begin
          state_d = S_NEXT;
        end else if (is_opp) begin
          run_d = run_q + 3'd1;
          row_d = row_q + step_r(dir_q);
          col_d = col_q + step_c(dir_q);
        end else if (run_q != 3'd0) begin
          // Bracketed: rewind to the first cell next to pos and flip outward.
          row_d   = $signed({1'b0, pos_q[5:3]}) + step_r(dir_q);
          col_d   = $signed({1'b0, pos_q[2:0]}) + step_c(dir_q);
          state_d = S_FLIP;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_FLIP: begin
        row_d = row_q + step_r(dir_q);
        col_d = col_q + step_c(dir_q);
        run_d = run_q - 3'd1;
        if (run_q == 3'd1) state_d = S_NEXT;
      end
      S_NEXT: begin
        run_d = '0;
        if (dir_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          dir_d   = dir_q + 3'd1;
          row_d   = $signed({1'b0, pos_q[5:3]}) + step_r(dir_q + 3'd1);
          col_d   = $signed({1'b0, pos_q[2:0]}) + step_c(dir_q + 3'd1);
          state_d = S_SCAN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_FLIP) begin
      rv_d  = !dry_d;
      ra_d  = {row_d[2:0], col_d[2:0]};
      cnt_d = cnt_q + 6'd1;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      black_q <= 1'b0;
      dir_q   <= '0;
      run_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      rv_q    <= 1'b0;
      ra_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      black_q <= black_d;
      dir_q   <= dir_d;
      run_q   <= run_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rv_q    <= rv_d;
      ra_q    <= ra_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dry_q   <= dry_d;
    end
  end

endmodule

// File: tb/tb_reversi_flip_scanner.sv
// Purpose: directed bench for reversi_flip_scanner. A ray-walking board model predicts every
//   flip, its cycle, the done cycle and the final count; hand-computed literals pin the model.
// Optional feature macro: REVERSI_DRYRUN_EN enables the dry-run scenario.
module tb_reversi_flip_scanner;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  reversi_flip_scanner_if bus ();
  logic [2:0] board [64];
  assign bus.rd_data = board[bus.rd_addr];

  reversi_flip_scanner dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_pass = 0;
  int n_tot  = 0;
  bit exp_rv [256];
  int exp_ra [256];
  int exp_done;
  int exp_cnt;
  int got_q [$];

  task automatic chk(input string name, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 3'd0;
  endtask

  // Walks each ray on the board array; cycle 1 is the first cycle after the accepting edge.
  task automatic build_model(input int p, input bit blk, input bit dry);
    int dr [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    int dc [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int r0, c0, t, own, opp;
    r0 = p / 8; c0 = p % 8; t = 0;
    own = blk ? 2 : 3; opp = blk ? 3 : 2;
    exp_cnt = 0;
    for (int i = 0; i < 256; i++) begin exp_rv[i] = 1'b0; exp_ra[i] = 0; end
    for (int d = 0; d < 8; d++) begin
      int r, c, k;
      bit on, cap;
      r = r0 + dr[d]; c = c0 + dc[d]; k = 0;
      on = (r >= 0 && r < 8 && c >= 0 && c < 8);
      while (on && int'(board[r*8+c]) == opp) begin
        k++; r += dr[d]; c += dc[d];
        on = (r >= 0 && r < 8 && c >= 0 && c < 8);
      end
      t += k + 1;
      cap = on && (k > 0) && (int'(board[r*8+c]) == own);
      if (cap) begin
        for (int i = 1; i <= k; i++) begin
          t++;
          exp_rv[t] = !dry;
          exp_ra[t] = (r0 + i*dr[d]) * 8 + (c0 + i*dc[d]);
          exp_cnt++;
        end
      end
      t++;
    end
    exp_done = t + 1;
  endtask

  task automatic apply_start(input int p, input bit blk, input bit dry);
    @(negedge clk);
    bus.pos = 6'(p); bus.set_black = blk; bus.start = 1'b1;
`ifdef REVERSI_DRYRUN_EN
    bus.dry_run = dry;
`else
    if (dry) $display("note: dry run requested without REVERSI_DRYRUN_EN");
`endif
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Full scan with per-cycle comparison against the model; a stray start mid-scan must be ignored.
  task automatic run_scan(input int p, input bit blk, input bit dry);
    build_model(p, blk, dry);
    got_q.delete();
    apply_start(p, blk, dry);
    for (int t = 1; t <= exp_done + 1; t++) begin
      if (t > 1) @(negedge clk);
      if (t == 3) begin bus.start = 1'b1; bus.pos = 6'd63; end
      else if (t == 4) bus.start = 1'b0;
      chk($sformatf("busy@%0d", t), int'(bus.busy), int'(t <= exp_done));
      chk($sformatf("reverse_valid@%0d", t), int'(bus.reverse_valid), int'(exp_rv[t]));
      if (bus.reverse_valid) got_q.push_back(int'(bus.reverse_addr));
      if (bus.reverse_valid && exp_rv[t])
        chk($sformatf("reverse_addr@%0d", t), int'(bus.reverse_addr), exp_ra[t]);
      chk($sformatf("done@%0d", t), int'(bus.done), int'(t == exp_done));
      if (t >= exp_done)
        chk($sformatf("flip_count@%0d", t), int'(bus.flip_count), exp_cnt);
    end
  endtask

  task automatic setup_initial();
    clear_board();
    board[27] = 3'd3; board[36] = 3'd3; board[28] = 3'd2; board[35] = 3'd2;
  endtask

  task automatic setup_row0(input bit with_black);
    clear_board();
    for (int i = 1; i <= 6; i++) board[i] = 3'd3;
    board[7] = with_black ? 3'd2 : 3'd3;
  endtask

  initial begin
    int seen;
    resetn = 1'b1;
    bus.start = 1'b0; bus.pos = '0; bus.set_black = 1'b0;
`ifdef REVERSI_DRYRUN_EN
    bus.dry_run = 1'b0;
`endif
    clear_board();
    repeat (2) @(negedge clk);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset reverse_valid", int'(bus.reverse_valid), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset flip_count", int'(bus.flip_count), 0);
    chk("reset rd_addr", int'(bus.rd_addr), 0);
    chk("reset reverse_addr", int'(bus.reverse_addr), 0);
    resetn = 1'b0;

    // Opening board, black plays 6'o23: flips 27 only
    setup_initial();
    run_scan(8'o23, 1'b1, 1'b0);
    chk("t1 model done cycle", exp_done, 19);
    chk("t1 pulse count", got_q.size(), 1);
    if (got_q.size() > 0) chk("t1 pulse addr", got_q[0], 27);
    chk("t1 flip_count", int'(bus.flip_count), 1);

    // Row 0 capture of six cells
    setup_row0(1'b1);
    run_scan(0, 1'b1, 1'b0);
    chk("t2 model done cycle", exp_done, 29);
    chk("t2 pulse count", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      chk($sformatf("t2 pulse %0d addr", i), got_q[i], i + 1);
    chk("t2 flip_count", int'(bus.flip_count), 6);

    // Row 0 all white to the edge: no capture, no wrap
    setup_row0(1'b0);
    board[8] = 3'd2;
    run_scan(0, 1'b1, 1'b0);
    chk("t3 model done cycle", exp_done, 24);
    chk("t3 pulse count", got_q.size(), 0);
    chk("t3 flip_count", int'(bus.flip_count), 0);

    // Empty board, corner 63, white mover
    clear_board();
    run_scan(63, 1'b0, 1'b0);
    chk("t4 model done cycle", exp_done, 17);
    chk("t4 pulse count", got_q.size(), 0);

    // Reset after the third flip pulse of the row-0 capture
    setup_row0(1'b1);
    got_q.delete();
    apply_start(0, 1'b1, 1'b0);
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.reverse_valid) begin
        seen++;
        got_q.push_back(int'(bus.reverse_addr));
      end
      if (seen == 3) break;
      @(negedge clk);
    end
    chk("t5 pulses before reset", seen, 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      chk($sformatf("t5 pre-reset pulse %0d addr", i), got_q[i], i + 1);
    resetn = 1'b1;
    #1;
    chk("t5 busy in reset", int'(bus.busy), 0);
    chk("t5 reverse_valid in reset", int'(bus.reverse_valid), 0);
    chk("t5 done in reset", int'(bus.done), 0);
    chk("t5 flip_count in reset", int'(bus.flip_count), 0);
    @(negedge clk);
    resetn = 1'b0;
    run_scan(0, 1'b1, 1'b0);
    chk("t5 rerun pulse count", got_q.size(), 6);
    chk("t5 rerun flip_count", int'(bus.flip_count), 6);

`ifdef REVERSI_DRYRUN_EN
    // Dry run on the opening move: same timing and count, no pulses
    setup_initial();
    run_scan(8'o23, 1'b1, 1'b1);
    chk("t6 model done cycle", exp_done, 19);
    chk("t6 pulse count", got_q.size(), 0);
    chk("t6 flip_count", int'(bus.flip_count), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
